nibble_packer: RTL

//  Write-side counterpart of the word-to-nibble selector on the Zigbee symbol path.

---
 rtl/zigbee_pkg.sv | 13 +
 rtl/nibble_packer.sv | 85 ++++++++
 2 files changed

// File: rtl/zigbee_pkg.sv
// Shared constants and types for the Zigbee symbol path (nibble <-> packed word).
package zigbee_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 32;
    localparam int NIBS   = WORD_W / NIB_W;
    localparam int CNT_W  = $clog2(NIBS);
    localparam int LEN_W  = $clog2(NIBS + 1);

    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/nibble_packer.sv
// Packs LSB-first 4-bit symbol nibbles into 32-bit words behind one output holding register.
module nibble_packer
    import zigbee_pkg::*;
(
    input  logic             inClk,
    input  logic             inResetN,
    input  nib_t             inNib,
    input  logic             inNibValid,
    output logic             outNibReady,
    input  logic             inFlush,
    output word_t            outWord,
    output logic             outWordValid,
    input  logic             inWordReady,
    output logic [LEN_W-1:0] outWordLen
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            acc_q, acc_d, acc_merged;
    word_t            word_q, word_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             vld_q, vld_d;
    logic             pend_q, pend_d;

    logic             last_slot, out_free, cmpl_pend, flush_req, nib_acc, close;
    logic [LEN_W-1:0] new_len;
    logic [NIBS-1:0]  slot_we;

    assign last_slot = (cnt_q == CNT_W'(NIBS - 1));
    assign out_free  = ~vld_q | inWordReady;
    assign cmpl_pend = last_slot | inFlush;
    assign flush_req = inFlush | pend_q;

    // Only the word-closing nibble has to wait for the holding register; a
    // pending flush also blocks input so nothing slips in ahead of the close.
    assign outNibReady = ~pend_q & ~(cmpl_pend & vld_q & ~inWordReady);
    assign nib_acc     = inNibValid & outNibReady;

    for (genvar k = 0; k < NIBS; k++) begin : g_slot
        assign slot_we[k] = nib_acc & (cnt_q == CNT_W'(k));
        assign acc_merged[k*NIB_W +: NIB_W] = slot_we[k] ? inNib : acc_q[k*NIB_W +: NIB_W];
    end

    assign new_len = LEN_W'(cnt_q) + LEN_W'(nib_acc);
    assign close   = (nib_acc & last_slot)
                   | (flush_req & out_free & ((cnt_q != '0) | nib_acc));

    always_comb begin
        acc_d  = acc_merged;
        cnt_d  = cnt_q + CNT_W'(nib_acc);
        word_d = word_q;
        len_d  = len_q;
        vld_d  = vld_q & ~inWordReady;
        pend_d = flush_req & (cnt_q != '0) & ~out_free;
        if (close) begin
            word_d = acc_merged;
            len_d  = new_len;
            vld_d  = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            word_q <= '0;
            len_q  <= '0;
            vld_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            len_q  <= len_d;
            vld_q  <= vld_d;
            pend_q <= pend_d;
        end
    end

    assign outWord      = word_q;
    assign outWordLen   = len_q;
    assign outWordValid = vld_q;

endmodule
